// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction-memory addressing and the IF/ID
// pipeline register. Handles decode stalls, EX redirects with wrong-path
// squash, and a halt sequence (RUN -> DRAIN -> HALT) that only reset leaves.
module fetch_stage #(
   parameter logic [15:0] RESET_PC     = 16'h0000,
   parameter logic [15:0] NOP_INSTR    = 16'h0000,
   parameter logic [3:0]  HALT_OP      = 4'hF,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   output logic [15:0] pc_out,
   output logic [15:0] instr_out,
   output logic        valid_out,
   output logic        halted,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

   state_t      state, state_nxt;
   logic [15:0] pc, pc_nxt;
   logic [15:0] seq_pc;
   logic [15:0] pc_out_nxt;
   logic [15:0] instr_out_nxt;
   logic        valid_out_nxt;
   logic [3:0]  drain_cnt, drain_nxt;
   logic [15:0] fetch_count_nxt;

   // Sequential successor; 16-bit arithmetic wraps 16'hFFFE -> 16'h0000.
   assign seq_pc    = pc + 16'd2;
   assign imem_addr = pc;
   assign halted    = (state == HALT);

   // Next-state and next-register values: redirect beats stall beats fetch.
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      pc_out_nxt      = pc_out;
      instr_out_nxt   = instr_out;
      valid_out_nxt   = valid_out;
      drain_nxt       = drain_cnt;
      fetch_count_nxt = fetch_count;
      case (state)
         RUN, DRAIN: begin
            if (redirect) begin
               // Squash the wrong-path fetch and cancel any speculative halt.
               pc_nxt        = redirect_pc;
               pc_out_nxt    = 16'h0000;
               instr_out_nxt = NOP_INSTR;
               valid_out_nxt = 1'b0;
               state_nxt     = RUN;
               drain_nxt     = 4'd0;
            end else if (!stall) begin
               if (state == RUN) begin
                  pc_nxt          = seq_pc;
                  pc_out_nxt      = seq_pc;
                  instr_out_nxt   = imem_data;
                  valid_out_nxt   = 1'b1;
                  fetch_count_nxt = fetch_count + 16'd1;
                  if (imem_data[15:12] == HALT_OP) begin
                     state_nxt = DRAIN;
                     drain_nxt = DRAIN_INIT;
                  end
               end else begin
                  // Draining: PC holds, bubbles flow into decode.
                  pc_out_nxt    = 16'h0000;
                  instr_out_nxt = NOP_INSTR;
                  valid_out_nxt = 1'b0;
                  drain_nxt     = drain_cnt - 4'd1;
                  if (drain_cnt <= 4'd1) begin
                     state_nxt = HALT;
                     drain_nxt = 4'd0;
                  end
               end
            end
         end
         HALT: begin
            // Frozen until reset; stall and redirect are ignored.
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // State, PC, IF/ID and counter registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= RUN;
         pc          <= RESET_PC;
         pc_out      <= 16'h0000;
         instr_out   <= NOP_INSTR;
         valid_out   <= 1'b0;
         drain_cnt   <= 4'd0;
         fetch_count <= 16'h0000;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         pc_out      <= pc_out_nxt;
         instr_out   <= instr_out_nxt;
         valid_out   <= valid_out_nxt;
         drain_cnt   <= drain_nxt;
         fetch_count <= fetch_count_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural reference model, a
// per-cycle compare process, directed literal checks and random stimulus.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic [15:0] pc_out;
   logic [15:0] instr_out;
   logic        valid_out;
   logic        halted;
   logic [15:0] fetch_count;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Reference model state.
   logic [15:0] m_pc, m_pc_out, m_instr, m_count;
   logic        m_valid, m_halted;
   int          m_left;          // bubbles still to emit before halting

   fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .pc_out      (pc_out),
      .instr_out   (instr_out),
      .valid_out   (valid_out),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model, updated from the same inputs the DUT samples.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pc <= 16'h0000; m_pc_out <= 16'h0000; m_instr <= 16'h0000;
         m_valid <= 1'b0; m_halted <= 1'b0; m_left <= 0; m_count <= 16'h0000;
      end else if (m_halted) begin
         // frozen
      end else if (redirect) begin
         m_pc <= redirect_pc; m_pc_out <= 16'h0000; m_instr <= 16'h0000;
         m_valid <= 1'b0; m_left <= 0;
      end else if (stall) begin
         // hold
      end else if (m_left > 0) begin
         m_pc_out <= 16'h0000; m_instr <= 16'h0000; m_valid <= 1'b0;
         m_left <= m_left - 1;
         if (m_left == 1) m_halted <= 1'b1;
      end else begin
         m_pc <= m_pc + 16'd2; m_pc_out <= m_pc + 16'd2; m_instr <= imem_data;
         m_valid <= 1'b1; m_count <= m_count + 16'd1;
         if (imem_data[15:12] == 4'hF) m_left <= 3;
      end
   end

   // Compare every output against the model away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_addr",   imem_addr,          m_pc);
         chk("pc_out",      pc_out,             m_pc_out);
         chk("instr_out",   instr_out,          m_instr);
         chk("valid_out",   {15'd0, valid_out}, {15'd0, m_valid});
         chk("halted",      {15'd0, halted},    {15'd0, m_halted});
         chk("fetch_count", fetch_count,        m_count);
      end
   end

   // Apply one cycle of inputs; returns just after the following falling edge.
   task automatic cyc(input logic s, input logic r, input logic [15:0] rpc, input logic [15:0] d);
      stall = s; redirect = r; redirect_pc = rpc; imem_data = d;
      @(negedge clk); #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_imem_addr"}, imem_addr, 16'h0000);
      chk({tag, "_pc_out"},    pc_out,    16'h0000);
      chk({tag, "_instr_out"}, instr_out, 16'h0000);
      chk({tag, "_valid"},     {15'd0, valid_out}, 16'h0000);
      chk({tag, "_halted"},    {15'd0, halted},    16'h0000);
      chk({tag, "_count"},     fetch_count, 16'h0000);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic rst_pulse(input string tag);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check_reset_vals(tag);
      @(negedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; imem_data = 16'h0000;
      #3;
      check_reset_vals("reset");
      @(negedge clk); #1;
      rst = 1'b1;
      chk_en = 1'b1;

      // Four sequential fetches.
      repeat (4) cyc(1'b0, 1'b0, 16'h0000, 16'h1234);
      chk("seq_pc_out", pc_out, 16'h0008);
      chk("seq_count", fetch_count, 16'h0004);
      chk("seq_imem_addr", imem_addr, 16'h0008);
      chk("seq_instr", instr_out, 16'h1234);

      // Two stalled cycles hold everything, then fetch resumes.
      repeat (2) cyc(1'b1, 1'b0, 16'h0000, 16'h5555);
      chk("stall_imem_addr", imem_addr, 16'h0008);
      chk("stall_count", fetch_count, 16'h0004);
      chk("stall_pc_out", pc_out, 16'h0008);
      cyc(1'b0, 1'b0, 16'h0000, 16'h1234);
      chk("resume_pc_out", pc_out, 16'h000A);

      // Redirect with stall (and a halt opcode on the bus): redirect wins.
      cyc(1'b1, 1'b1, 16'h0040, 16'hF000);
      chk("redir_valid", {15'd0, valid_out}, 16'h0000);
      chk("redir_instr", instr_out, 16'h0000);
      chk("redir_imem_addr", imem_addr, 16'h0040);
      cyc(1'b0, 1'b0, 16'h0000, 16'h1234);
      chk("redir_pc_out", pc_out, 16'h0042);
      chk("redir_valid2", {15'd0, valid_out}, 16'h0001);

      // Halt sequence from 16'h0010.
      cyc(1'b0, 1'b1, 16'h0010, 16'h0000);
      cyc(1'b0, 1'b0, 16'h0000, 16'hF000);
      chk("halt_instr", instr_out, 16'hF000);
      chk("halt_imem_addr", imem_addr, 16'h0012);
      repeat (2) cyc(1'b0, 1'b0, 16'h0000, 16'h1234);
      chk("drain_halted", {15'd0, halted}, 16'h0000);
      chk("drain_valid", {15'd0, valid_out}, 16'h0000);
      cyc(1'b0, 1'b0, 16'h0000, 16'h1234);
      chk("halt_halted", {15'd0, halted}, 16'h0001);
      repeat (2) cyc(1'b0, 1'b1, 16'h0200, 16'h1234);
      chk("halt_frozen_addr", imem_addr, 16'h0012);
      chk("halt_frozen_halted", {15'd0, halted}, 16'h0001);

      // Asynchronous reset mid-cycle.
      rst_pulse("async_rst");

      // Halt cancelled by redirect during DRAIN.
      cyc(1'b0, 1'b0, 16'h0000, 16'hF000);
      cyc(1'b0, 1'b1, 16'h0080, 16'h1234);
      chk("cancel_halted", {15'd0, halted}, 16'h0000);
      chk("cancel_addr", imem_addr, 16'h0080);
      repeat (4) cyc(1'b0, 1'b0, 16'h0000, 16'h1234);
      chk("cancel_halted2", {15'd0, halted}, 16'h0000);
      chk("cancel_addr2", imem_addr, 16'h0088);
      chk("cancel_valid", {15'd0, valid_out}, 16'h0001);

      // PC wrap at the top of the address space.
      cyc(1'b0, 1'b1, 16'hFFFE, 16'h0000);
      cyc(1'b0, 1'b0, 16'h0000, 16'h1234);
      chk("wrap_imem_addr", imem_addr, 16'h0000);
      chk("wrap_pc_out", pc_out, 16'h0000);

      // Randomized traffic; reset occasionally once halted.
      for (int i = 0; i < 2500; i++) begin
         if (m_halted && ($urandom_range(3) == 0)) begin
            rst_pulse("rand_rst");
         end else begin
            cyc(($urandom_range(3) == 0), ($urandom_range(9) == 0),
                16'($urandom) & 16'hFFFE, 16'($urandom));
         end
      end

      // fetch_count wraps from 16'hFFFF to 0.
      rst_pulse("cnt_rst");
      for (int i = 0; i < 70000 && m_count != 16'hFFFF; i++)
         cyc(1'b0, 1'b0, 16'h0000, 16'h1234);
      chk("cnt_max", fetch_count, 16'hFFFF);
      cyc(1'b0, 1'b0, 16'h0000, 16'h1234);
      chk("cnt_wrap", fetch_count, 16'h0000);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
